core_64bit_divider: RTL and testbench
=====================================

Name: core_64bit_divider

Overview:
- Sequential iterative (restoring, shift-subtract) integer divider for the RV64 M-extension: DIV, DIVU, REM and REMU.
- It is the subtracting counterpart of the core's combinational 64-bit adder. It produces one quotient bit per cycle.
- Sits in the execute stage beside the ALU and talks to the issue logic through a valid/ready handshake on both the request and result sides.

Parameters:
- XLEN, 64, operand and result width. Must be a power of two, at least 8.
- CNT_W, $clog2(XLEN)+1, width of the iteration counter.

Ports:
- i_clk  input  1  core clock; all state changes on its rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_div_valid  input  1  request valid.
- o_div_ready  output  1  divider can accept a request.
- i_div_srcA  input  XLEN  dividend.
- i_div_srcB  input  XLEN  divisor.
- i_div_signed  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU).
- i_div_rem  input  1  1 = return remainder, 0 = return quotient.
- i_div_flush  input  1  pipeline flush; aborts any operation.
- o_div_valid  output  1  result valid.
- i_div_ready  input  1  consumer accepts result.
- o_div_result  output  XLEN  quotient or remainder.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - state=IDLE, o_div_ready=1, o_div_valid=0, o_div_result=0.
  - Counter, partial remainder, quotient and captured flags all cleared.
- States: IDLE, BUSY, DONE.
  - o_div_ready=1 only in IDLE.
  - o_div_valid=1 only in DONE.
- IDLE:
  - Accept on i_div_valid && o_div_ready.
  - Capture signed and rem flags.
  - Capture |srcA| and |srcB| when signed; raw values when unsigned.
  - Record quotient sign = signA^signB and remainder sign = signA (signed only).
  - Special cases go directly to DONE next cycle, result precomputed:
    - srcB==0: quotient=all ones, remainder=srcA.
    - signed && srcA==2^(XLEN-1) && srcB==all ones: quotient=srcA, remainder=0.
  - Otherwise go to BUSY with counter=XLEN.
- BUSY, one step per cycle:
  - Shift {rem,quo} left by 1.
  - Trial-subtract the divisor from rem using an XLEN+1-bit difference.
  - If non-negative: rem=difference, quo LSB=1. Else quo LSB=0.
  - Decrement counter. When counter reaches 1 on a step, the next state is DONE.
  - Exactly XLEN BUSY cycles per operation.
- Entering DONE:
  - o_div_result is registered with sign correction: negate quotient if quotient sign is set; negate remainder if remainder sign is set.
  - Select quotient or remainder per the captured rem flag.
- Latency:
  - Request accepted at edge T gives o_div_valid at T+XLEN+1 (normal case) or T+1 (special case).
- DONE:
  - o_div_valid and o_div_result are held stable until i_div_ready=1. Then return to IDLE and o_div_valid=0 next cycle.
  - No new request is accepted in the same cycle as result handoff. Throughput is at most one operation per XLEN+2 cycles.
- Flush:
  - i_div_flush=1 in any state forces IDLE next cycle and o_div_valid=0.
  - It discards the operation and overrides a simultaneous i_div_valid or result handshake.
  - Output registers o_div_result keep their stale value. Consumers must qualify with o_div_valid.
- Operand stability:
  - Inputs are sampled only at acceptance. Later changes to srcA, srcB or the flags have no effect.
- Reset mid-operation: immediate return to the reset state; no result is produced.
- All arithmetic is modulo 2^XLEN. Signed overflow is covered by the special case above; no other exceptions are raised.

Test Plan:
- DIVU 100/7 -> o_div_valid exactly XLEN+1 cycles after accept, result=14. The same with REMU -> result=2.
- DIV -7/2 -> result=-3 (0xFFFF_FFFF_FFFF_FFFD). REM -7/2 -> result=-1. REM 7/-2 -> result=1.
- DIVU 5/0 -> result=0xFFFF_FFFF_FFFF_FFFF at accept+1. REMU 5/0 -> result=5. DIV 0x8000_0000_0000_0000 / -1 -> result=0x8000_0000_0000_0000, REM -> 0; both at accept+1.
- Backpressure: hold i_div_ready=0 for 10 cycles in DONE -> o_div_valid and result stable, o_div_ready=0. Raise i_div_ready -> IDLE next cycle, o_div_ready=1.
- Assert i_div_flush during BUSY cycle 20 together with a new i_div_valid -> IDLE next cycle, no o_div_valid ever for either. A following DIVU 9/3 then returns 3 with normal latency.
- Drop i_rst_n mid-BUSY, change operands during BUSY in a separate run -> the reset case returns all outputs to reset values immediately. The operand-change case still returns the result of the originally captured operands.

Source files
------------

// File: rtl/core_64bit_divider.sv
// ---------------------------------------------------------------------------
// core_64bit_divider
//   Iterative restoring (shift-subtract) divider for the RV64 M-extension
//   DIV / DIVU / REM / REMU. Produces one quotient bit per cycle, so a normal
//   operation occupies XLEN BUSY cycles. Divide-by-zero and signed overflow
//   are resolved at acceptance and skip straight to DONE.
//
// Ports
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_div_valid / o_div_ready  request handshake (ready only in IDLE)
//   i_div_srcA, i_div_srcB     dividend, divisor (sampled at acceptance only)
//   i_div_signed               1 = DIV/REM, 0 = DIVU/REMU
//   i_div_rem                  1 = remainder, 0 = quotient
//   i_div_flush                abort; forces IDLE next cycle
//   o_div_valid / i_div_ready  result handshake (valid only in DONE)
//   o_div_result               registered quotient or remainder
// ---------------------------------------------------------------------------
module core_64bit_divider #(
    parameter int XLEN  = 64,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_div_valid,
    output logic            o_div_ready,
    input  logic [XLEN-1:0] i_div_srcA,
    input  logic [XLEN-1:0] i_div_srcB,
    input  logic            i_div_signed,
    input  logic            i_div_rem,
    input  logic            i_div_flush,
    output logic            o_div_valid,
    input  logic            i_div_ready,
    output logic [XLEN-1:0] o_div_result
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [XLEN-1:0]   rem_reg, rem_next;
    logic [XLEN-1:0]   quo_reg, quo_next;
    logic [XLEN-1:0]   dvsr_reg, dvsr_next;
    logic [XLEN-1:0]   result_reg, result_next;
    logic              rem_flag_reg, rem_flag_next;
    logic              qneg_reg, qneg_next;
    logic              rneg_reg, rneg_next;

    // Operand preparation at acceptance
    logic              sign_a, sign_b, div_zero, overflow;
    logic [XLEN-1:0]   abs_a, abs_b;

    assign sign_a   = i_div_signed & i_div_srcA[XLEN-1];
    assign sign_b   = i_div_signed & i_div_srcB[XLEN-1];
    assign abs_a    = sign_a ? -i_div_srcA : i_div_srcA;
    assign abs_b    = sign_b ? -i_div_srcB : i_div_srcB;
    assign div_zero = (i_div_srcB == '0);
    assign overflow = i_div_signed && (i_div_srcA == MIN_NEG) && (i_div_srcB == '1);

    // One restoring step. The shifted partial remainder can reach XLEN+1
    // bits when the divisor has its MSB set, so the trial difference carries
    // one extra bit on top of that to expose the borrow.
    logic [XLEN:0]     shifted;
    logic [XLEN+1:0]   trial;
    logic              fits;
    logic [XLEN-1:0]   step_rem, step_quo, fin_q, fin_r;

    assign shifted  = {rem_reg, quo_reg[XLEN-1]};
    assign trial    = {1'b0, shifted} - {2'b00, dvsr_reg};
    assign fits     = ~trial[XLEN+1];
    assign step_rem = fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    assign step_quo = {quo_reg[XLEN-2:0], fits};
    assign fin_q    = qneg_reg ? -step_quo : step_quo;
    assign fin_r    = rneg_reg ? -step_rem : step_rem;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        rem_next      = rem_reg;
        quo_next      = quo_reg;
        dvsr_next     = dvsr_reg;
        result_next   = result_reg;
        rem_flag_next = rem_flag_reg;
        qneg_next     = qneg_reg;
        rneg_next     = rneg_reg;

        // Flush discards everything, including a request or handoff in the
        // same cycle; the result register keeps its stale contents.
        if (i_div_flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_div_valid) begin
                        rem_flag_next = i_div_rem;
                        qneg_next     = sign_a ^ sign_b;
                        rneg_next     = sign_a;
                        if (div_zero) begin
                            result_next = i_div_rem ? i_div_srcA : '1;
                            state_next  = DONE;
                        end else if (overflow) begin
                            result_next = i_div_rem ? '0 : i_div_srcA;
                            state_next  = DONE;
                        end else begin
                            dvsr_next  = abs_b;
                            quo_next   = abs_a;
                            rem_next   = '0;
                            cnt_next   = CNT_W'(XLEN);
                            state_next = BUSY;
                        end
                    end
                end
                BUSY: begin
                    rem_next = step_rem;
                    quo_next = step_quo;
                    cnt_next = cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        result_next = rem_flag_reg ? fin_r : fin_q;
                        state_next  = DONE;
                    end
                end
                DONE: begin
                    if (i_div_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            dvsr_reg     <= '0;
            result_reg   <= '0;
            rem_flag_reg <= 1'b0;
            qneg_reg     <= 1'b0;
            rneg_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            rem_reg      <= rem_next;
            quo_reg      <= quo_next;
            dvsr_reg     <= dvsr_next;
            result_reg   <= result_next;
            rem_flag_reg <= rem_flag_next;
            qneg_reg     <= qneg_next;
            rneg_reg     <= rneg_next;
        end
    end

    assign o_div_ready  = (state_reg == IDLE);
    assign o_div_valid  = (state_reg == DONE);
    assign o_div_result = result_reg;

endmodule

// File: tb/tb_core_64bit_divider.sv
module tb_core_64bit_divider;

    localparam int XLEN = 64;
    localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;

    logic            clk;
    logic            rst_n;
    logic            div_valid;
    logic            div_ready_out;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            div_signed;
    logic            div_rem;
    logic            div_flush;
    logic            res_valid;
    logic            res_ready;
    logic [XLEN-1:0] result;

    int n_cmp = 0;
    int n_err = 0;

    core_64bit_divider #(.XLEN(XLEN)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_div_valid  (div_valid),
        .o_div_ready  (div_ready_out),
        .i_div_srcA   (src_a),
        .i_div_srcB   (src_b),
        .i_div_signed (div_signed),
        .i_div_rem    (div_rem),
        .i_div_flush  (div_flush),
        .o_div_valid  (res_valid),
        .i_div_ready  (res_ready),
        .o_div_result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics in plain arithmetic.
    function automatic bit is_special(input logic [63:0] a, input logic [63:0] b, input logic s);
        return (b == 64'd0) || (s && a == MIN_NEG && b == 64'hFFFF_FFFF_FFFF_FFFF);
    endfunction

    function automatic logic [63:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic s, input logic r);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (b == 64'd0) return r ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        if (s && a == MIN_NEG && b == 64'hFFFF_FFFF_FFFF_FFFF) return r ? 64'd0 : a;
        if (s) begin
            sa = longint'(a);
            sb = longint'(b);
            return r ? 64'(sa % sb) : 64'(sa / sb);
        end
        ua = a;
        ub = b;
        return r ? (ua % ub) : (ua / ub);
    endfunction

    // Issue one operation, wait for the result, optionally hold it under
    // backpressure, then hand it off and confirm return to IDLE.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic s, input logic r, input int hold, input bit scramble);
        logic [63:0] exp;
        int          exp_lat;
        int          lat;
        exp     = ref_model(a, b, s, r);
        exp_lat = is_special(a, b, s) ? 1 : XLEN + 1;
        @(negedge clk);
        chk({tag, "_ready"}, 64'(div_ready_out), 64'd1);
        div_valid  = 1'b1;
        src_a      = a;
        src_b      = b;
        div_signed = s;
        div_rem    = r;
        res_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        div_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 200) begin
            if (scramble) begin
                src_a      = {$urandom, $urandom};
                src_b      = {$urandom, $urandom};
                div_signed = 1'($urandom);
                div_rem    = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_result"}, result, exp);
        $display("op %s a=%h b=%h signed=%0d rem=%0d -> %h (exp %h) lat=%0d",
                 tag, a, b, s, r, result, exp, lat);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
            end
            chk({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
            chk({tag, "_hold_result"}, result, exp);
            chk({tag, "_hold_ready"}, 64'(div_ready_out), 64'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, "_post_valid"}, 64'(res_valid), 64'd0);
        chk({tag, "_post_ready"}, 64'(div_ready_out), 64'd1);
    endtask

    initial begin
        logic [63:0] ra, rb;
        logic        rs, rr;
        bit          saw_valid;

        rst_n      = 1'b0;
        div_valid  = 1'b0;
        src_a      = '0;
        src_b      = '0;
        div_signed = 1'b0;
        div_rem    = 1'b0;
        div_flush  = 1'b0;
        res_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ready", 64'(div_ready_out), 64'd1);
        chk("reset_valid", 64'(res_valid), 64'd0);
        chk("reset_result", result, 64'd0);
        rst_n = 1'b1;

        // Directed cases
        run_op("divu_100_7", 64'd100, 64'd7, 1'b0, 1'b0, 0, 1'b0);
        run_op("remu_100_7", 64'd100, 64'd7, 1'b0, 1'b1, 0, 1'b0);
        run_op("div_m7_2", -64'sd7, 64'd2, 1'b1, 1'b0, 0, 1'b0);
        run_op("rem_m7_2", -64'sd7, 64'd2, 1'b1, 1'b1, 0, 1'b0);
        run_op("rem_7_m2", 64'd7, -64'sd2, 1'b1, 1'b1, 0, 1'b0);
        run_op("divu_5_0", 64'd5, 64'd0, 1'b0, 1'b0, 0, 1'b0);
        run_op("remu_5_0", 64'd5, 64'd0, 1'b0, 1'b1, 0, 1'b0);
        run_op("div_ovf", MIN_NEG, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0, 1'b0);
        run_op("rem_ovf", MIN_NEG, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0, 1'b0);
        run_op("divu_big_dvsr", 64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0001, 1'b0, 1'b1, 0, 1'b0);
        run_op("backpressure", 64'd1000, 64'd33, 1'b0, 1'b0, 10, 1'b0);

        // Flush on BUSY cycle 20 together with a new request
        @(negedge clk);
        div_valid  = 1'b1;
        src_a      = 64'd1000;
        src_b      = 64'd3;
        div_signed = 1'b0;
        div_rem    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        div_valid = 1'b0;
        repeat (19) @(negedge clk);
        div_flush = 1'b1;
        div_valid = 1'b1;
        src_a     = 64'd77;
        src_b     = 64'd0;
        @(posedge clk);
        @(negedge clk);
        div_flush = 1'b0;
        div_valid = 1'b0;
        chk("flush_ready", 64'(div_ready_out), 64'd1);
        chk("flush_valid", 64'(res_valid), 64'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (res_valid) saw_valid = 1'b1;
        end
        chk("flush_no_result", 64'(saw_valid), 64'd0);
        $display("op flush_busy20 discarded, saw_valid=%0d", saw_valid);
        run_op("divu_9_3", 64'd9, 64'd3, 1'b0, 1'b0, 0, 1'b0);

        // Reset in the middle of BUSY; previous result (3) must be cleared
        @(negedge clk);
        div_valid  = 1'b1;
        src_a      = 64'd12345;
        src_b      = 64'd11;
        div_signed = 1'b0;
        div_rem    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        div_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 64'(div_ready_out), 64'd1);
        chk("midrst_valid", 64'(res_valid), 64'd0);
        chk("midrst_result", result, 64'd0);
        $display("op midbusy_reset ready=%0d valid=%0d result=%h", div_ready_out, res_valid, result);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (res_valid) saw_valid = 1'b1;
        end
        chk("midrst_no_result", 64'(saw_valid), 64'd0);

        // Operand changes after acceptance must not matter
        run_op("scramble_div", -64'sd1000003, 64'd17, 1'b1, 1'b0, 0, 1'b1);
        run_op("scramble_rem", 64'hDEAD_BEEF_1234_5678, 64'h0000_0001_0000_0003, 1'b0, 1'b1, 0, 1'b1);

        // Randomized operations against the reference model
        for (int k = 0; k < 30; k++) begin
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: rb = 64'($urandom_range(1, 20));
                1: rb = -64'($urandom_range(1, 20));
                2: rb = ra >> $urandom_range(1, 63);
                3: rb = {32'd0, $urandom};
                default: rb = {$urandom, $urandom};
            endcase
            if ($urandom_range(0, 9) == 0) rb = 64'd0;
            rs = 1'($urandom);
            rr = 1'($urandom);
            run_op($sformatf("rand%0d", k), ra, rb, rs, rr, $urandom_range(0, 2), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
